instr_fetch_unit: RTL

Instruction fetch front end of the RV32I core: it produces the instruction words consumed by `InstructionDecoder`.
- Holds the PC and issues word-aligned read requests to instruction memory.
- Buffers in-order responses together with their PC in a small FIFO and hands them downstream over a valid/ready handshake.
- On a branch/jump redirect from Execute, flushes buffered and in-flight instructions and restarts fetch at the new target.

---
 rtl/instr_fetch_unit_pkg.sv | 19 +
 rtl/instr_fetch_fifo.sv | 67 ++++++
 rtl/instr_fetch_unit.sv | 113 +++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the RV32I instruction fetch front end:
// FSM encodings, word geometry and the buffered entry layout.
package instr_fetch_unit_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic {
        FETCH_ST_FETCH = 1'b0,
        FETCH_ST_DRAIN = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_fifo.sv
// Synchronous instruction buffer holding {pc, instr} entries; flush empties it
// immediately and takes priority over a same-cycle push or pop.
module instr_fetch_fifo
    import instr_fetch_unit_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  fetch_entry_t     push_data,
    input  logic             pop,
    output fetch_entry_t     head,
    output logic [CNT_W-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    fetch_entry_t     entries_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is data only; occupancy is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push && !flush) entries_q[wr_ptr_q] <= push_data;
    end

    assign head  = entries_q[rd_ptr_q];
    assign count = count_q;

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !flush && count_q == FULL));
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(pop && !flush && count_q == '0));

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch front end: PC, credit-limited request issue, in-order response buffering,
// and redirect handling that drains stale in-flight responses.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W:0]  CREDITS = (CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [31:0]     PC_STEP = 32'(INSTR_BYTES);

    fetch_state_e     state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] discard_q, discard_d;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W:0]   credit_sum;
    fetch_entry_t     fifo_head, push_entry;
    logic             req_fire, push, pop, fifo_valid;
    logic [1:0]       redirect_pc_unused;

    assign redirect_pc_unused = redirect_pc[1:0];
    assign credit_sum = {1'b0, fifo_count} + {1'b0, outstanding_q};
    assign req_fire   = imem_req_valid & imem_req_ready;
    assign fifo_valid = (fifo_count != '0);
    assign pop        = fifo_valid & instr_ready & ~redirect_valid;
    assign push       = imem_rsp_valid & (discard_q == '0) & ~redirect_valid;

    // Every in-flight request is newer than the buffered ones, so the oldest one sits at pc - 4*outstanding.
    assign push_entry.pc    = pc_q - 32'(outstanding_q) * PC_STEP;
    assign push_entry.instr = imem_rsp_data;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= FETCH_ST_FETCH;
            pc_q          <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (redirect_valid)
            state_d = (discard_d != '0) ? FETCH_ST_DRAIN : FETCH_ST_FETCH;
        else if (state_q == FETCH_ST_DRAIN && discard_d == '0)
            state_d = FETCH_ST_FETCH;
    end

    always_comb begin
        imem_req_valid = 1'b0;
        if (rst_n && state_q == FETCH_ST_FETCH && !redirect_valid && credit_sum < CREDITS)
            imem_req_valid = 1'b1;
    end

    always_comb begin
        pc_d          = pc_q;
        discard_d     = discard_q;
        outstanding_d = outstanding_q + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);
        if (req_fire) pc_d = pc_q + PC_STEP;
        // A response arriving with the redirect is already stale, so it leaves the discard budget.
        if (redirect_valid) begin
            pc_d      = {redirect_pc[31:2], 2'b00};
            discard_d = outstanding_q - CNT_W'(imem_rsp_valid);
        end else if (imem_rsp_valid && discard_q != '0) begin
            discard_d = discard_q - 1'b1;
        end
    end

    assign imem_req_addr = pc_q;
    assign instr_valid   = fifo_valid;
    assign instr         = fifo_valid ? fifo_head.instr : '0;
    assign instr_pc      = fifo_valid ? fifo_head.pc    : '0;

    instr_fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_valid),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count)
    );

    a_credit_limit: assert property (@(posedge clk) disable iff (!rst_n)
        credit_sum <= CREDITS);

endmodule
